// File: rtl/enter_button_conditioner.sv
// Enter push-button front end: two-flop synchronizer, counter debounce FSM, one-cycle press pulse.
// Define ENTER_AUTOREPEAT_EN to re-fire Enter_pulse while the button stays held.
module enter_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 50000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 20000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic Enter_pulse,
  output logic button_level
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  logic            sync1_q, sync_b_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            level_q, level_d;
  logic            press_accept;

  // Only sync_b_q is used past this point; button_in is asynchronous.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync_b_q <= 1'b0;
    end else begin
      sync1_q  <= button_in;
      sync_b_q <= sync1_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_accept = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sync_b_q) begin
          state_d = StPressWait;
          cnt_d   = CntOne;
        end
      end
      StPressWait: begin
        if (!sync_b_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntDone) begin
          state_d      = StPressed;
          cnt_d        = '0;
          press_accept = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StPressed: begin
        if (!sync_b_q) begin
          state_d = StReleaseWait;
          cnt_d   = CntOne;
        end
      end
      StReleaseWait: begin
        if (sync_b_q) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntDone) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_d = (state_d == StPressed) || (state_d == StReleaseWait);

`ifdef ENTER_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY_CYCLES);
  localparam logic [RepW-1:0] RepRate  = RepW'(REPEAT_RATE_CYCLES);

  logic [RepW-1:0] rep_q, rep_d, rep_inc, rep_target;
  logic            rep_armed_q, rep_armed_d;
  logic            rep_fire;

  assign rep_inc    = rep_q + RepW'(1);
  // First repeat waits the long delay, later ones the shorter rate.
  assign rep_target = rep_armed_q ? RepRate : RepDelay;

  always_comb begin
    rep_d       = rep_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    if (state_d == StIdle) begin
      rep_d       = '0;
      rep_armed_d = 1'b0;
    end else if (state_q == StPressed && state_d == StPressed) begin
      if (rep_inc == rep_target) begin
        rep_fire    = 1'b1;
        rep_d       = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  assign pulse_d = press_accept | rep_fire;
`else
  assign pulse_d = press_accept;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign Enter_pulse  = pulse_q;
  assign button_level = level_q;

endmodule

// File: tb/tb_enter_button_conditioner.sv
// Self-checking bench for enter_button_conditioner: directed scenarios plus random button
// activity, checked cycle by cycle against a sample-history reference model.
module tb_enter_button_conditioner;

  localparam int unsigned Deb   = 4;
  localparam int unsigned Delay = 10;
  localparam int unsigned Rate  = 5;

  logic clock;
  logic reset;
  logic button_in;
  logic Enter_pulse;
  logic button_level;

  enter_button_conditioner #(
    .DEBOUNCE_CYCLES    (Deb),
    .REPEAT_DELAY_CYCLES(Delay),
    .REPEAT_RATE_CYCLES (Rate)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .button_in   (button_in),
    .Enter_pulse (Enter_pulse),
    .button_level(button_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: the accepted level flips once the last Deb synchronized samples all
  // disagree with it. Repeats follow cumulative time spent held in the pressed state.
  bit m_s1, m_s2;
  bit m_level, m_pulse, m_last;
  bit hist[$];
  int m_held;

  function automatic void model_step(input bit b, input bit r);
    bit sample, was_pressed, now_pressed, all_flip;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_last = 0; m_held = 0;
      hist.delete();
      return;
    end
    sample = m_s2;
    hist.push_back(sample);
    if (hist.size() > Deb) void'(hist.pop_front());
    was_pressed = m_level && m_last;
    m_pulse = 0;
    all_flip = (hist.size() == Deb);
    foreach (hist[i]) if (hist[i] == m_level) all_flip = 0;
    if (all_flip) begin
      m_level = !m_level;
      m_pulse = m_level;
      m_held  = 0;
    end
    m_last = sample;
    now_pressed = m_level && m_last;
`ifdef ENTER_AUTOREPEAT_EN
    if (was_pressed && now_pressed) begin
      m_held++;
      if (m_held == Delay || (m_held > Delay && (m_held - Delay) % Rate == 0)) m_pulse = 1;
    end
`else
    if (was_pressed && now_pressed) m_held++;
`endif
    m_s2 = m_s1;
    m_s1 = b;
  endfunction

  int pulses_seen;
  int level_falls;
  int level_highs;
  bit prev_pulse;
  bit prev_level;

  task automatic tick(input bit b, input bit r);
    @(negedge clock);
    button_in = b;
    reset     = r;
    @(posedge clock);
    model_step(b, r);
    #1;
    check_eq("enter_pulse", int'(Enter_pulse), int'(m_pulse));
    check_eq("button_level", int'(button_level), int'(m_level));
    check_eq("pulse_gap", int'(prev_pulse && Enter_pulse), 0);
    if (Enter_pulse) pulses_seen++;
    if (button_level) level_highs++;
    if (prev_level && !button_level) level_falls++;
    prev_pulse = Enter_pulse;
    prev_level = button_level;
  endtask

  task automatic seg(input bit b, input int n, input bit r = 0);
    for (int i = 0; i < n; i++) tick(b, r);
  endtask

  task automatic clear_counts();
    pulses_seen = 0;
    level_falls = 0;
    level_highs = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    prev_pulse = 0;
    prev_level = 0;
    button_in  = 1'b0;
    reset      = 1'b1;
    clear_counts();

    // Held through reset: one pulse after a full debounce from release.
    seg(1, 3, 1);
    check_eq("reset_no_pulse", pulses_seen, 0);
    check_eq("reset_no_level", level_highs, 0);
    seg(1, 12);
    check_eq("post_reset_pulses", pulses_seen, 1);
    seg(0, 10);

    clear_counts();
    seg(1, 20);
    seg(0, 20);
`ifdef ENTER_AUTOREPEAT_EN
    check_eq("clean_press_pulses", pulses_seen, 3);
`else
    check_eq("clean_press_pulses", pulses_seen, 1);
`endif
    check_eq("clean_press_falls", level_falls, 1);

    clear_counts();
    for (int k = 0; k < 3; k++) begin
      seg(1, 2);
      seg(0, 2);
    end
    seg(1, 12);
    seg(0, 10);
    check_eq("bounce_pulses", pulses_seen, 1);

    clear_counts();
    seg(1, 3);
    seg(0, 10);
    check_eq("glitch_pulses", pulses_seen, 0);
    check_eq("glitch_level", level_highs, 0);

    clear_counts();
    seg(1, 10);
    seg(0, 3);
    seg(1, 3);
    seg(0, 10);
    check_eq("release_bounce_pulses", pulses_seen, 1);
    check_eq("release_bounce_falls", level_falls, 1);

    clear_counts();
    seg(1, 4);
    seg(1, 2, 1);
    seg(0, 8);
    check_eq("reset_abort_pulses", pulses_seen, 0);

    clear_counts();
    seg(1, 32);
    seg(0, 10);
`ifdef ENTER_AUTOREPEAT_EN
    check_eq("long_hold_pulses", pulses_seen, 5);
`else
    check_eq("long_hold_pulses", pulses_seen, 1);
`endif

    // Random activity with occasional resets.
    for (int s = 0; s < 300; s++) begin
      int len;
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30))
                                         : int'($urandom_range(1, 6));
      if ($urandom_range(0, 24) == 0) seg(lvl, int'($urandom_range(1, 3)), 1);
      else seg(lvl, len);
    end
    seg(0, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
